// File: rtl/compute_layer_scheduler.sv
// rtl/compute_layer_scheduler.sv - sequences one convolution layer through Compute_Processor, one filter pass at a time
//
// Ports:
//   Clk, Reset_n                      clock, synchronous active-low reset
//   Start, Abort                      layer run / stop requests (one-cycle)
//   Num_filters_m1, Data_length_m1    layer configuration, latched on accepted Start
//   Weight_load_req / Weight_load_ack weight-load handshake for Filter_index
//   Proc_Enable, Proc_Done            processor enable and done strobe
//   Proc_Write_M                      result-RAM write monitor
//   Filter_index                      current filter pass
//   Busy, Layer_Done, Error           status: non-idle, completion pulse, sticky error
module compute_layer_scheduler #(
    parameter int Dataset_depth_counter_bits = 9,
    parameter int Filter_counter_bits        = 3,
    parameter int Timeout_bits               = 16
) (
    input  logic                                  Clk,
    input  logic                                  Reset_n,
    input  logic                                  Start,
    input  logic                                  Abort,
    input  logic [Filter_counter_bits-1:0]        Num_filters_m1,
    input  logic [Dataset_depth_counter_bits-1:0] Data_length_m1,
    output logic                                  Weight_load_req,
    input  logic                                  Weight_load_ack,
    output logic                                  Proc_Enable,
    input  logic                                  Proc_Done,
    input  logic                                  Proc_Write_M,
    output logic [Filter_counter_bits-1:0]        Filter_index,
    output logic                                  Busy,
    output logic                                  Layer_Done,
    output logic                                  Error
);

    localparam int D = Dataset_depth_counter_bits;
    localparam int F = Filter_counter_bits;
    localparam int T = Timeout_bits;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t         state;
    logic [F-1:0]   num_filters_m1_q;
    logic [D-1:0]   data_length_m1_q;
    logic [D:0]     write_count;
    logic [T-1:0]   watchdog;

    logic [D:0]     write_count_next;
    logic [D:0]     expected_count;
    logic [T-1:0]   watchdog_next;
    logic           watchdog_expired;

    // The write count is one bit wider than the length field so a full
    // 2^D-result pass is representable; a write coincident with Done counts.
    always_comb begin
        write_count_next = write_count + {{D{1'b0}}, Proc_Write_M};
        expected_count   = {1'b0, data_length_m1_q} + {{D{1'b0}}, 1'b1};
        watchdog_next    = watchdog + {{(T-1){1'b0}}, 1'b1};
        watchdog_expired = &watchdog_next;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state            <= S_IDLE;
            num_filters_m1_q <= '0;
            data_length_m1_q <= '0;
            write_count      <= '0;
            watchdog         <= '0;
            Weight_load_req  <= 1'b0;
            Proc_Enable      <= 1'b0;
            Filter_index     <= '0;
            Busy             <= 1'b0;
            Layer_Done       <= 1'b0;
            Error            <= 1'b0;
        end else if (state == S_IDLE) begin
            // Start together with Abort is treated as no request.
            if (Start && !Abort) begin
                num_filters_m1_q <= Num_filters_m1;
                data_length_m1_q <= Data_length_m1;
                Filter_index     <= '0;
                Error            <= 1'b0;
                Busy             <= 1'b1;
                Weight_load_req  <= 1'b1;
                state            <= S_LOAD;
            end
        end else if (Abort) begin
            // Abort outranks ack, done and timeout; Error is left as is.
            state           <= S_IDLE;
            Weight_load_req <= 1'b0;
            Proc_Enable     <= 1'b0;
            Busy            <= 1'b0;
            Layer_Done      <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (Weight_load_ack) begin
                        Weight_load_req <= 1'b0;
                        Proc_Enable     <= 1'b1;
                        write_count     <= '0;
                        watchdog        <= '0;
                        state           <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (Proc_Done) begin
                        Proc_Enable <= 1'b0;
                        write_count <= write_count_next;
                        if (write_count_next != expected_count) begin
                            Error <= 1'b1;
                        end
                        state <= S_NEXT;
                    end else if (watchdog_expired) begin
                        Error       <= 1'b1;
                        Proc_Enable <= 1'b0;
                        Busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        write_count <= write_count_next;
                        watchdog    <= watchdog_next;
                    end
                end
                S_NEXT: begin
                    if (Filter_index == num_filters_m1_q) begin
                        Layer_Done <= 1'b1;
                        state      <= S_FINISH;
                    end else begin
                        Filter_index    <= Filter_index + {{(F-1){1'b0}}, 1'b1};
                        Weight_load_req <= 1'b1;
                        state           <= S_LOAD;
                    end
                end
                S_FINISH: begin
                    Layer_Done <= 1'b0;
                    Busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    Weight_load_req <= 1'b0;
                    Proc_Enable     <= 1'b0;
                    Busy            <= 1'b0;
                    Layer_Done      <= 1'b0;
                    state           <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compute_layer_scheduler.sv
// tb/tb_compute_layer_scheduler.sv - self-checking bench for compute_layer_scheduler
module tb_compute_layer_scheduler;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;

    logic       start = 0, abort = 0, ack = 0, done = 0, wr = 0;
    logic [2:0] nf_in = 0;
    logic [8:0] dl_in = 0;
    logic       req, en, busy, ld, err;
    logic [2:0] fidx;

    logic       t_start = 0, t_abort = 0, t_ack = 0, t_done = 0, t_wr = 0;
    logic [2:0] t_nf = 0;
    logic [8:0] t_dl = 0;
    logic       t_req, t_en, t_busy, t_ld, t_err;
    logic [2:0] t_fidx;

    always #5 Clk = ~Clk;

    compute_layer_scheduler dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(start), .Abort(abort),
        .Num_filters_m1(nf_in), .Data_length_m1(dl_in),
        .Weight_load_req(req), .Weight_load_ack(ack),
        .Proc_Enable(en), .Proc_Done(done), .Proc_Write_M(wr),
        .Filter_index(fidx), .Busy(busy), .Layer_Done(ld), .Error(err)
    );

    compute_layer_scheduler #(.Timeout_bits(4)) t_dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(t_start), .Abort(t_abort),
        .Num_filters_m1(t_nf), .Data_length_m1(t_dl),
        .Weight_load_req(t_req), .Weight_load_ack(t_ack),
        .Proc_Enable(t_en), .Proc_Done(t_done), .Proc_Write_M(t_wr),
        .Filter_index(t_fidx), .Busy(t_busy), .Layer_Done(t_ld), .Error(t_err)
    );

    int n_vec = 0;
    int n_bad = 0;
    int ld_count = 0;

    typedef struct {
        int fidx;
        int err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int         nf;
        int         dl;
        int         ack_dly;
        int         bad_pass;
        int         delta;
        logic [7:0] coin;
        bit         spur;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge Clk);
    endtask

    always @(negedge Clk) begin
        if (ld === 1'b1) begin
            exp_t e;
            ld_count++;
            if (sb.size() == 0) begin
                check("unexpected_layer_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("done_filter_index", fidx, e.fidx);
                check("done_error", err, e.err);
            end
        end
    end

    task automatic start_layer(input int nf, input int dl);
        nf_in = nf[2:0];
        dl_in = dl[8:0];
        start = 1;
        tick;
        start = 0;
        nf_in = ~nf_in;
        dl_in = ~dl_in;
        check("start_busy", busy, 1);
        check("start_req", req, 1);
        check("start_fidx", fidx, 0);
        check("start_err_clear", err, 0);
        check("start_enable", en, 0);
    endtask

    task automatic do_pass(input int p, input int ack_dly, input int nwr, input bit coin,
                           input bit spur, input bit abrt, input int exp_err);
        check("load_req", req, 1);
        check("load_fidx", fidx, p);
        if (spur) begin
            start = 1;
            nf_in = 3'd7;
            tick;
            start = 0;
            check("spur_start_req", req, 1);
        end
        for (int i = 0; i < ack_dly; i++) begin
            tick;
            check("req_held", req, 1);
        end
        ack = 1;
        tick;
        ack = 0;
        check("enable_after_ack", en, 1);
        check("req_after_ack", req, 0);
        for (int i = 0; i < nwr; i++) begin
            wr = 1;
            if (coin && i == nwr - 1) begin
                done = 1;
                abort = abrt;
            end
            tick;
            done = 0;
        end
        wr = 0;
        if (!(coin && nwr > 0)) begin
            done = 1;
            abort = abrt;
            tick;
        end
        done = 0;
        abort = 0;
        if (!abrt) begin
            check("enable_after_done", en, 0);
            check("busy_in_next", busy, 1);
            check("error_after_pass", err, exp_err);
        end
    endtask

    task automatic run_layer(input vec_t v);
        int   exp_err = 0;
        int   ld_before;
        int   nwr;
        exp_t e;
        for (int p = 0; p <= v.nf; p++)
            if (p == v.bad_pass && v.delta != 0) exp_err = 1;
        e.fidx = v.nf;
        e.err  = exp_err;
        sb.push_back(e);
        ld_before = ld_count;
        exp_err = 0;
        start_layer(v.nf, v.dl);
        for (int p = 0; p <= v.nf; p++) begin
            nwr = v.dl + 1 + ((p == v.bad_pass) ? v.delta : 0);
            if (nwr != v.dl + 1) exp_err = 1;
            do_pass(p, v.ack_dly, nwr, v.coin[p], v.spur && p == 0, 1'b0, exp_err);
            tick;
        end
        check("finish_layer_done", ld, 1);
        check("finish_busy", busy, 1);
        tick;
        check("idle_busy", busy, 0);
        check("idle_layer_done", ld, 0);
        check("layer_done_pulses", ld_count - ld_before, 1);
    endtask

    initial begin
        int cnt;
        int t_seen;

        vecs[0] = '{nf: 2, dl: 9,   ack_dly: 3, bad_pass: -1, delta: 0,  coin: 8'h00, spur: 0};
        vecs[1] = '{nf: 2, dl: 9,   ack_dly: 1, bad_pass: 1,  delta: -1, coin: 8'h01, spur: 0};
        vecs[2] = '{nf: 7, dl: 511, ack_dly: 0, bad_pass: -1, delta: 0,  coin: 8'h00, spur: 0};
        vecs[3] = '{nf: 0, dl: 0,   ack_dly: 0, bad_pass: -1, delta: 0,  coin: 8'h01, spur: 1};
        vecs[4] = '{nf: 1, dl: 3,   ack_dly: 2, bad_pass: 0,  delta: 1,  coin: 8'h00, spur: 0};
        vecs[5] = '{nf: 3, dl: 2,   ack_dly: 0, bad_pass: 3,  delta: -3, coin: 8'hFF, spur: 0};
        vecs[6] = '{nf: 1, dl: 5,   ack_dly: 1, bad_pass: -1, delta: 0,  coin: 8'h02, spur: 0};

        tick;
        tick;
        check("rst_req", req, 0);
        check("rst_en", en, 0);
        check("rst_fidx", fidx, 0);
        check("rst_busy", busy, 0);
        check("rst_ld", ld, 0);
        check("rst_err", err, 0);
        Reset_n = 1;
        tick;

        done = 1; ack = 1; wr = 1; abort = 1;
        tick;
        done = 0; ack = 0; wr = 0; abort = 0;
        check("idle_spurious_busy", busy, 0);
        check("idle_spurious_en", en, 0);
        check("idle_spurious_err", err, 0);
        start = 1; abort = 1;
        tick;
        start = 0; abort = 0;
        check("start_abort_idle", busy, 0);
        check("start_abort_req", req, 0);

        for (int v = 0; v < 6; v++) run_layer(vecs[v]);

        // Abort coincident with Done on filter 1, with Error already set.
        start_layer(3, 4);
        do_pass(0, 1, 4, 1'b0, 1'b0, 1'b0, 1);
        tick;
        do_pass(1, 0, 5, 1'b1, 1'b0, 1'b1, 1);
        check("abort_busy", busy, 0);
        check("abort_en", en, 0);
        check("abort_req", req, 0);
        check("abort_err_kept", err, 1);
        check("abort_fidx", fidx, 1);
        repeat (3) tick;
        check("abort_stays_idle", busy, 0);
        run_layer(vecs[6]);

        // Reset during LOAD of filter 4.
        start_layer(5, 1);
        do_pass(0, 0, 1, 1'b0, 1'b0, 1'b0, 1);
        tick;
        for (int p = 1; p < 4; p++) begin
            do_pass(p, 0, 2, 1'b0, 1'b0, 1'b0, 1);
            tick;
        end
        check("pre_reset_req", req, 1);
        check("pre_reset_fidx", fidx, 4);
        Reset_n = 0;
        tick;
        check("mid_rst_req", req, 0);
        check("mid_rst_en", en, 0);
        check("mid_rst_fidx", fidx, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ld", ld, 0);
        check("mid_rst_err", err, 0);
        Reset_n = 1;
        tick;

        // Watchdog expiry on the narrow-timeout instance.
        t_nf = 0;
        t_dl = 3;
        t_start = 1;
        tick;
        t_start = 0;
        check("t_busy", t_busy, 1);
        t_ack = 1;
        tick;
        t_ack = 0;
        cnt = 0;
        t_seen = 0;
        while (t_en === 1'b1 && cnt < 40) begin
            cnt++;
            tick;
            if (t_ld === 1'b1) t_seen++;
        end
        check("t_enable_cycles", cnt, 15);
        check("t_busy_after", t_busy, 0);
        check("t_err", t_err, 1);
        check("t_no_layer_done", t_seen, 0);
        repeat (2) tick;
        check("t_err_sticky", t_err, 1);

        check("pending_layer_done", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/compute_layer_scheduler.md
# compute_layer_scheduler

Sequences one convolution layer through `Compute_Processor` by running one filter pass at a time. For each pass it requests a weight load, then enables the processor and waits for its done strobe. It also checks that the processor wrote the expected number of results. It sits between the top-level layer control and a single `Compute_Processor` instance, which it drives through `Enable` / `Done_M`.

## Interface
Parameters:
- `Dataset_depth_counter_bits`, 9, width of the data-length field (max 512 results per pass).
- `Filter_counter_bits`, 3, width of the filter index (max 8 filters).
- `Timeout_bits`, 16, width of the per-pass watchdog counter.

Ports:
- `Clk` in 1: single clock, all logic on rising edge.
- `Reset_n` in 1: synchronous, active-low reset.
- `Start` in 1: one-cycle request to run a layer; honoured only in IDLE.
- `Abort` in 1: one-cycle request to stop the layer; honoured in any non-IDLE state.
- `Num_filters_m1` in `Filter_counter_bits`: number of filters minus 1; latched on accepted `Start`.
- `Data_length_m1` in `Dataset_depth_counter_bits`: results per pass minus 1; latched on accepted `Start`.
- `Weight_load_req` out 1: weight-load request for `Filter_index`.
- `Weight_load_ack` in 1: weight-load complete.
- `Proc_Enable` out 1: drives `Compute_Processor.Enable`.
- `Proc_Done` in 1: from `Done_M`.
- `Proc_Write_M` in 1: monitor of `Result_RAM_write_M`.
- `Filter_index` out `Filter_counter_bits`: current filter pass.
- `Busy` out 1: high in every state except IDLE.
- `Layer_Done` out 1: one-cycle pulse when the layer completes.
- `Error` out 1: sticky error flag.

## Operation
- States: IDLE, LOAD, RUN, NEXT, FINISH.
- **IDLE:**
  - On `Start`, latch both config fields, clear `Filter_index`, clear `Error`, and go to LOAD.
- **LOAD:**
  - `Weight_load_req` is high.
  - When `Weight_load_ack` is sampled high, go to RUN.
  - Request is level-held until ack.
- **RUN:**
  - `Proc_Enable` is high.
  - The write counter (`Dataset_depth_counter_bits`+1 bits, cleared on entry to RUN) increments on every `Proc_Write_M`, including a write in the same cycle as `Proc_Done`.
  - The watchdog increments every cycle.
  - When `Proc_Done` is sampled high, go to NEXT. If the final write count ≠ `Data_length_m1`+1, set `Error`.
  - If the watchdog reaches all-ones before `Proc_Done`, set `Error` and go to IDLE without a `Layer_Done` pulse.
- **NEXT:**
  - Lasts one cycle and guarantees `Proc_Enable` is low for at least one cycle between passes.
  - If `Filter_index` == `Num_filters_m1`, go to FINISH.
  - Otherwise increment `Filter_index` and go to LOAD.
- **FINISH:**
  - Pulse `Layer_Done` for one cycle and go to IDLE.
- **Abort:**
  - In any non-IDLE state, `Abort` forces IDLE on the next edge.
  - `Proc_Enable` and `Weight_load_req` drop on that edge.
  - No `Layer_Done` pulse; `Error` is unchanged.
  - `Abort` has priority over `Proc_Done`, `Weight_load_ack` and timeout in the same cycle.
- `Start` outside IDLE is ignored, as are `Start` and `Abort` together in IDLE.
- `Proc_Done` and `Weight_load_ack` outside their own states are ignored.
- `Proc_Write_M` outside RUN is ignored and does not set `Error`.
- `Error` persists through FINISH and IDLE and clears only on reset or the next accepted `Start`.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `Weight_load_req`=0, `Proc_Enable`=0, `Filter_index`=0, `Busy`=0, `Layer_Done`=0, `Error`=0, all counters 0.
- `Reset_n` low mid-layer returns the block to IDLE on that edge with all outputs at their reset values.
- `Start` sampled at edge N: `Busy` and `Weight_load_req` are high from edge N+1.
- Ack sampled at edge M: `Weight_load_req` is low and `Proc_Enable` is high from edge M+1.
- `Proc_Done` sampled at edge D: `Proc_Enable` is low from D+1 (NEXT).
- The next pass's `Weight_load_req` rises at D+2, or `Layer_Done` pulses at D+2 for the last filter.
- `Busy` falls at D+3 on the last filter.
- Minimum per-pass overhead is 2 cycles plus the ack latency.
- With `Num_filters_m1`=7, `Filter_index` runs 0..7 and never wraps.

## Test plan
- **Nominal layer:** `Num_filters_m1`=2, `Data_length_m1`=9, ack after 3 cycles, 10 writes, then `Proc_Done` → 3 passes, `Filter_index` 0,1,2, one `Layer_Done` pulse, `Error`=0.
- **Write-count mismatch:** pass 1 issues 9 writes, with the last write coincident with `Proc_Done` in pass 0 → `Error` set after pass 1 and still 1 at `Layer_Done`; the layer completes all filters.
- **Timeout:** `Timeout_bits`=4, `Proc_Done` never asserted → `Error`=1, return to IDLE 15 cycles after RUN entry, no `Layer_Done`.
- **Abort:** `Abort` in the same cycle as `Proc_Done` on filter 1 → IDLE next cycle, `Proc_Enable`=0, no `Layer_Done`; a following `Start` restarts at filter 0 with `Error` cleared.
- **Reset and spurious inputs:** `Reset_n` low during LOAD of filter 4 → all outputs at reset values next edge. Separately, `Start` while `Busy` and `Proc_Done` in IDLE → no effect.
- **Max config:** `Num_filters_m1`=7, `Data_length_m1`=511, 512 writes per pass → 8 passes, no `Error`, exactly one `Layer_Done`.
